csi2_crc_check_ctrl: RTL

//  Sequences one csi2_crc_calc instance to check CSI-2 long-packet payload CRC.

---
 rtl/csi2_crc_pkg.sv | 15 +
 rtl/csi2_crc_calc.sv | 61 ++++++
 rtl/csi2_crc_check_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/csi2_crc_pkg.sv
// Shared constants and state encoding for the CSI-2 payload CRC checker.
package csi2_crc_pkg;

  localparam logic [15:0] CSI2_CRC_POLY = 16'h1021;
  localparam logic [15:0] CSI2_CRC_INIT = 16'hFFFF;

  typedef logic [2:0] crc_ctrl_state_t;

  localparam crc_ctrl_state_t ST_IDLE    = 3'd0;
  localparam crc_ctrl_state_t ST_PAYLOAD = 3'd1;
  localparam crc_ctrl_state_t ST_CRC_LO  = 3'd2;
  localparam crc_ctrl_state_t ST_CRC_HI  = 3'd3;
  localparam crc_ctrl_state_t ST_REPORT  = 3'd4;

endpackage

// File: rtl/csi2_crc_calc.sv
// Generic byte-wide CRC engine with registered output, optional reflection and xorout.
module csi2_crc_calc #(
  parameter int                  CRC_SIZE   = 16,
  parameter int                  DATA_WIDTH = 8,
  parameter logic [CRC_SIZE-1:0] POLY       = 16'h1021,
  parameter string               REF_IN     = "TRUE",
  parameter string               REF_OUT    = "TRUE",
  parameter logic [CRC_SIZE-1:0] XOR_OUT    = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  rst_i,
  input  logic                  soft_reset_i,
  input  logic [CRC_SIZE-1:0]   init_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [CRC_SIZE-1:0]   crc_o
);

  localparam bit REF_IN_B  = (REF_IN == "TRUE");
  localparam bit REF_OUT_B = (REF_OUT == "TRUE");

  logic [CRC_SIZE-1:0]   crc_q, crc_d;
  logic [CRC_SIZE-1:0]   crc_nxt;
  logic [CRC_SIZE-1:0]   crc_out;
  logic [DATA_WIDTH-1:0] data_ord;
  logic                  fb;

  // The register holds the non-reflected remainder; reflection is applied at the edges.
  always_comb begin
    data_ord = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      data_ord[i] = REF_IN_B ? data_i[DATA_WIDTH-1-i] : data_i[i];
    crc_nxt = crc_q;
    fb      = 1'b0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      fb      = crc_nxt[CRC_SIZE-1] ^ data_ord[i];
      crc_nxt = {crc_nxt[CRC_SIZE-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  always_comb begin
    crc_d = crc_q;
    if (rst_i)             crc_d = '0;
    else if (soft_reset_i) crc_d = init_i;
    else if (valid_i)      crc_d = crc_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) crc_q <= '0;
    else          crc_q <= crc_d;
  end

  always_comb begin
    crc_out = '0;
    for (int i = 0; i < CRC_SIZE; i++)
      crc_out[i] = REF_OUT_B ? crc_q[CRC_SIZE-1-i] : crc_q[i];
    crc_o = crc_out ^ XOR_OUT;
  end

endmodule

// File: rtl/csi2_crc_check_ctrl.sv
// Forwards a CSI-2 long-packet payload and checks its trailing CRC-16.
//  state   | meaning
//  IDLE    | waiting for a header, engine seeded on accept
//  PAYLOAD | pass-through of payload bytes into engine and downstream
//  CRC_LO  | capturing received CRC low byte
//  CRC_HI  | capturing received CRC high byte
//  REPORT  | one-cycle verdict, error counter update
module csi2_crc_check_ctrl
  import csi2_crc_pkg::*;
#(
  parameter int          WC_WIDTH  = 16,
  parameter int          CNT_WIDTH = 16,
  parameter logic [15:0] CRC_INIT  = CSI2_CRC_INIT
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 hdr_valid_i,
  output logic                 hdr_ready_o,
  input  logic [WC_WIDTH-1:0]  hdr_wc_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [7:0]           s_data_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [7:0]           m_data_o,
  output logic                 m_last_o,
  output logic                 crc_done_o,
  output logic                 crc_err_o,
  output logic [15:0]          crc_calc_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o
);

  localparam logic [WC_WIDTH-1:0]  WC_ONE  = WC_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  crc_ctrl_state_t      state_q, state_d;
  logic [WC_WIDTH-1:0]  remaining_q, remaining_d;
  logic [15:0]          rx_crc_q, rx_crc_d;
  logic [15:0]          crc_calc_q, crc_calc_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

  logic        in_payload;
  logic        hdr_hs;
  logic        pay_hs;
  logic        mismatch;
  logic [15:0] eng_crc;

  assign in_payload = (state_q == ST_PAYLOAD);
  assign hdr_hs     = (state_q == ST_IDLE) && hdr_valid_i;
  assign pay_hs     = in_payload && s_valid_i && m_ready_i;
  assign mismatch   = (rx_crc_q != eng_crc);

  csi2_crc_calc #(
    .CRC_SIZE   (16),
    .DATA_WIDTH (8),
    .POLY       (CSI2_CRC_POLY),
    .REF_IN     ("TRUE"),
    .REF_OUT    ("TRUE"),
    .XOR_OUT    (16'h0000)
  ) u_crc_calc (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .rst_i        (1'b0),
    .soft_reset_i (hdr_hs),
    .init_i       (CRC_INIT),
    .valid_i      (pay_hs),
    .data_i       (s_data_i),
    .crc_o        (eng_crc)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    rx_crc_d    = rx_crc_q;
    crc_calc_d  = crc_calc_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (hdr_valid_i) begin
          remaining_d = hdr_wc_i;
          state_d     = (hdr_wc_i != '0) ? ST_PAYLOAD : ST_CRC_LO;
        end
      end
      ST_PAYLOAD: begin
        if (pay_hs) begin
          remaining_d = remaining_q - WC_ONE;
          if (remaining_q == WC_ONE) state_d = ST_CRC_LO;
        end
      end
      ST_CRC_LO: begin
        if (s_valid_i) begin
          rx_crc_d[7:0] = s_data_i;
          state_d       = ST_CRC_HI;
        end
      end
      ST_CRC_HI: begin
        if (s_valid_i) begin
          rx_crc_d[15:8] = s_data_i;
          state_d        = ST_REPORT;
        end
      end
      ST_REPORT: begin
        crc_calc_d = eng_crc;
        if (mismatch && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_ONE;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      rx_crc_q    <= '0;
      crc_calc_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      rx_crc_q    <= rx_crc_d;
      crc_calc_q  <= crc_calc_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign hdr_ready_o = (state_q == ST_IDLE);
  assign s_ready_o   = in_payload ? m_ready_i
                                  : ((state_q == ST_CRC_LO) || (state_q == ST_CRC_HI));
  assign m_valid_o   = in_payload && s_valid_i;
  assign m_data_o    = s_data_i;
  assign m_last_o    = in_payload && (remaining_q == WC_ONE);
  assign crc_done_o  = (state_q == ST_REPORT);
  assign crc_err_o   = (state_q == ST_REPORT) && mismatch;
  assign crc_calc_o  = crc_calc_q;
  assign err_cnt_o   = err_cnt_q;

endmodule
